// File: rtl/conv1d_pkg.sv
// Shared constants for the conv1d requantize/pack stage: config register
// selects, int32/int8 limits and config reset values.
package conv1d_pkg;

    typedef enum logic [2:0] {
        CFG_BIAS       = 3'd0,
        CFG_MULT       = 3'd1,
        CFG_SHIFT      = 3'd2,
        CFG_OUT_OFFSET = 3'd3,
        CFG_ACT_MIN    = 3'd4,
        CFG_ACT_MAX    = 3'd5
    } cfg_sel_e;

    localparam logic signed [31:0] INT32_MIN  = 32'sh8000_0000;
    localparam logic signed [31:0] INT32_MAX  = 32'sh7FFF_FFFF;
    localparam logic signed [7:0]  INT8_MIN   = 8'sh80;
    localparam logic signed [7:0]  INT8_MAX   = 8'sh7F;
    localparam logic signed [31:0] MULT_RESET = 32'sh4000_0000;

endpackage

// File: rtl/conv1d_requant_packer_if.sv
// Accumulator input, config port and packed-word output of the requant packer.
interface conv1d_requant_packer_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_acc;
    logic        flush;
    logic        cfg_we;
    logic [2:0]  cfg_sel;
    logic [31:0] cfg_data;
    logic        busy;
    logic        cfg_err;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [2:0]  out_bytes;

    modport master (
        output in_valid, in_acc, flush, cfg_we, cfg_sel, cfg_data, out_ready,
        input  in_ready, busy, cfg_err, out_valid, out_data, out_bytes
    );

    modport slave (
        input  in_valid, in_acc, flush, cfg_we, cfg_sel, cfg_data, out_ready,
        output in_ready, busy, cfg_err, out_valid, out_data, out_bytes
    );

endinterface

// File: rtl/conv1d_requant_packer_srdhm.sv
// Two-stage saturating rounding doubling high-multiply: stage 2 forms the
// 64-bit product, stage 3 rounds it to the high word.
module requant_srdhm
    import conv1d_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic               x_valid,
    input  logic signed [31:0] x,
    input  logic signed [31:0] mult,
    output logic               p_valid,
    output logic               y_valid,
    output logic signed [31:0] y
);

    logic signed [63:0] p;
    logic               sat;
    logic signed [63:0] prod;
    logic signed [63:0] nudged;
    logic signed [63:0] biased;

    always_comb begin
        prod   = 64'(x) * 64'(mult);
        nudged = p + ((p >= 0) ? 64'sd1073741824 : -64'sd1073741823);
        // bias negative values so the arithmetic shift truncates toward zero
        biased = nudged + ((nudged < 0) ? 64'sd2147483647 : 64'sd0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_valid <= 1'b0;
            y_valid <= 1'b0;
            p       <= '0;
            sat     <= 1'b0;
            y       <= '0;
        end else if (en) begin
            p_valid <= x_valid;
            y_valid <= p_valid;
            p       <= prod;
            sat     <= (x == INT32_MIN) && (mult == INT32_MIN);
            y       <= sat ? INT32_MAX : 32'(biased >>> 31);
        end
    end

endmodule

// File: rtl/conv1d_requant_packer.sv
// Requantizes int32 conv1d accumulators to int8 (TFLite scheme) and packs
// four results per 32-bit word onto a valid/ready output.
module conv1d_requant_packer
    import conv1d_pkg::*;
#(
    parameter int unsigned PIPE_STAGES = 4,
    parameter int unsigned MAX_SHIFT   = 31
) (
    input  logic                     clk,
    input  logic                     reset,
    conv1d_requant_packer_if.slave   bus
);

    if (PIPE_STAGES != 4) begin : g_bad_pipe
        $error("conv1d_requant_packer: PIPE_STAGES must be 4");
    end

    logic signed [31:0] bias, mult, out_offset;
    logic        [4:0]  shift;
    logic signed [7:0]  act_min, act_max;

    logic               v1, v2, v3, v4;
    logic signed [31:0] x1, y3;
    logic        [7:0]  z4;

    logic [2:0][7:0]    pack_buf;
    logic [1:0]         pack_cnt;
    logic               flush_pend;
    logic               out_valid_q;
    logic [31:0]        out_data_q;
    logic [2:0]         out_bytes_q;
    logic               cfg_err_q;

    logic               stall, adv, emit, busy;
    logic [31:0]        mask, rem, thr;
    logic               round_up;
    logic signed [32:0] r_ext, z_ext, lo, hi, clamped;

    requant_srdhm u_srdhm (
        .clk     (clk),
        .reset   (reset),
        .en      (adv),
        .x_valid (v1),
        .x       (x1),
        .mult    (mult),
        .p_valid (v2),
        .y_valid (v3),
        .y       (y3)
    );

    // Only a completing word needs the output register while S4 holds data.
    assign stall = v4 && (pack_cnt == 2'd3) && out_valid_q && !bus.out_ready;
    assign adv   = !stall;
    assign emit  = flush_pend && !v1 && !v2 && !v3 && !v4 &&
                   (!out_valid_q || bus.out_ready);
    assign busy  = v1 || v2 || v3 || v4 || (pack_cnt != 2'd0) ||
                   out_valid_q || flush_pend;

    always_comb begin
        mask     = (32'd1 << shift) - 32'd1;
        rem      = y3 & mask;
        thr      = (mask >> 1) + {31'd0, y3[31]};
        round_up = rem > thr;
        r_ext    = 33'(y3 >>> shift) + {32'd0, round_up};
        z_ext    = r_ext + 33'(out_offset);
        lo       = 33'(act_min);
        hi       = 33'(act_max);
        if (z_ext < lo) begin
            clamped = lo;
        end else if (z_ext > hi) begin
            clamped = hi;
        end else begin
            clamped = z_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bias        <= '0;
            mult        <= MULT_RESET;
            shift       <= '0;
            out_offset  <= '0;
            act_min     <= INT8_MIN;
            act_max     <= INT8_MAX;
            cfg_err_q   <= 1'b0;
            v1          <= 1'b0;
            v4          <= 1'b0;
            x1          <= '0;
            z4          <= '0;
            pack_buf    <= '0;
            pack_cnt    <= '0;
            flush_pend  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_bytes_q <= '0;
        end else begin
            if (bus.cfg_we) begin
                if (busy) begin
                    cfg_err_q <= 1'b1;
                end else begin
                    case (bus.cfg_sel)
                        CFG_BIAS:       bias       <= bus.cfg_data;
                        CFG_MULT:       mult       <= bus.cfg_data;
                        CFG_SHIFT:      shift      <= (bus.cfg_data > MAX_SHIFT) ?
                                                      5'(MAX_SHIFT) : bus.cfg_data[4:0];
                        CFG_OUT_OFFSET: out_offset <= bus.cfg_data;
                        CFG_ACT_MIN:    act_min    <= bus.cfg_data[7:0];
                        CFG_ACT_MAX:    act_max    <= bus.cfg_data[7:0];
                        default:        ;
                    endcase
                end
            end

            if (adv) begin
                v1 <= bus.in_valid;
                x1 <= bus.in_acc + bias;
                v4 <= v3;
                z4 <= 8'(clamped);
            end

            if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // Completed or flushed words overwrite the drain above in the same cycle.
            if (adv && v4) begin
                if (pack_cnt == 2'd3) begin
                    out_data_q  <= {z4, pack_buf};
                    out_bytes_q <= 3'd4;
                    out_valid_q <= 1'b1;
                    pack_buf    <= '0;
                    pack_cnt    <= '0;
                end else begin
                    case (pack_cnt)
                        2'd0:    pack_buf[0] <= z4;
                        2'd1:    pack_buf[1] <= z4;
                        default: pack_buf[2] <= z4;
                    endcase
                    pack_cnt <= pack_cnt + 2'd1;
                end
            end else if (emit && (pack_cnt != 2'd0)) begin
                out_data_q  <= {8'h00, pack_buf};
                out_bytes_q <= {1'b0, pack_cnt};
                out_valid_q <= 1'b1;
                pack_buf    <= '0;
                pack_cnt    <= '0;
            end

            flush_pend <= bus.flush || (flush_pend && !emit);
        end
    end

    assign bus.in_ready  = !stall;
    assign bus.busy      = busy;
    assign bus.cfg_err   = cfg_err_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_bytes = out_bytes_q;

endmodule

// File: tb/tb_conv1d_requant_packer.sv
// Directed bench for conv1d_requant_packer with hand-computed packed words.
module tb_conv1d_requant_packer;
    import conv1d_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    logic [31:0] got_data[$];
    logic [2:0]  got_bytes[$];

    always #5 clk = ~clk;

    conv1d_requant_packer_if bus ();

    conv1d_requant_packer #(
        .PIPE_STAGES (4),
        .MAX_SHIFT   (31)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Inputs change #1 after posedge, so a negedge sample sees the handshake of the next edge.
    always @(negedge clk) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            got_data.push_back(bus.out_data);
            got_bytes.push_back(bus.out_bytes);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send(input logic [31:0] a);
        bit ok;
        int n;
        bus.in_valid = 1'b1;
        bus.in_acc   = a;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 200) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
            n++;
        end
        bus.in_valid = 1'b0;
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
    endtask

    task automatic pulse_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (bus.busy && n < 300) begin
            tick();
            n++;
        end
        if (bus.busy) check("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic cfg_write(input logic [2:0] sel, input logic [31:0] data);
        bus.cfg_we   = 1'b1;
        bus.cfg_sel  = sel;
        bus.cfg_data = data;
        tick();
        bus.cfg_we   = 1'b0;
    endtask

    task automatic wait_words(input int n);
        int k;
        k = 0;
        while (got_data.size() < n && k < 300) begin
            tick();
            k++;
        end
        if (got_data.size() < n) check("wait_words", 32'(got_data.size()), 32'(n));
    endtask

    task automatic expect_word(input string tag, input int idx,
                               input logic [31:0] d, input logic [2:0] b);
        if (got_data.size() > idx) begin
            check({tag, "_data"}, got_data[idx], d);
            check({tag, "_bytes"}, 32'(got_bytes[idx]), 32'(b));
        end else begin
            check({tag, "_missing"}, 32'(got_data.size()), 32'(idx + 1));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int n;
        int idx;

        bus.in_valid  = 1'b0;
        bus.in_acc    = '0;
        bus.flush     = 1'b0;
        bus.cfg_we    = 1'b0;
        bus.cfg_sel   = '0;
        bus.cfg_data  = '0;
        bus.out_ready = 1'b1;
        reset         = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_data", bus.out_data, 32'h0);
        check("rst_out_bytes", 32'(bus.out_bytes), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_cfg_err", 32'(bus.cfg_err), 32'd0);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        tick();

        // Default config: 100,200,-100,1000 -> 50,100,-50,127
        base = got_data.size();
        send(32'd100);
        send(32'd200);
        send(32'hFFFF_FF9C);
        send(32'd1000);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        check("latency", 32'(n), 32'd4);
        wait_words(base + 1);
        expect_word("default", base, 32'h7FCE_6432, 3'd4);

        // Partial word through flush, then an empty flush
        wait_idle();
        base = got_data.size();
        send(32'd50);
        send(32'd100);
        pulse_flush();
        wait_words(base + 1);
        expect_word("flush2", base, 32'h0000_3219, 3'd2);
        wait_idle();
        pulse_flush();
        repeat (20) tick();
        check("flush_empty_count", 32'(got_data.size()), 32'(base + 1));
        check("flush_empty_busy", 32'(bus.busy), 32'd0);

        // bias=100, out_offset=-60: input 0 -> 50 - 60 = -10
        base = got_data.size();
        cfg_write(CFG_BIAS, 32'd100);
        cfg_write(CFG_OUT_OFFSET, 32'hFFFF_FFC4);
        send(32'd0);
        pulse_flush();
        wait_words(base + 1);
        expect_word("bias_offset", base, 32'h0000_00F6, 3'd1);

        // shift=1 rounding: y = 2,-1,3,-3 -> 1,-1,2,-2
        do_reset();
        base = got_data.size();
        cfg_write(CFG_SHIFT, 32'd1);
        send(32'd3);
        send(32'hFFFF_FFFD);
        send(32'd6);
        send(32'hFFFF_FFFA);
        wait_words(base + 1);
        expect_word("shift1", base, 32'hFE02_FF01, 3'd4);

        // Saturating multiply; shift=100 stores 31 so INT32_MAX rounds to 1
        wait_idle();
        base = got_data.size();
        cfg_write(CFG_MULT, 32'h8000_0000);
        cfg_write(CFG_SHIFT, 32'd100);
        send(32'h8000_0000);
        pulse_flush();
        wait_words(base + 1);
        expect_word("shift_sat", base, 32'h0000_0001, 3'd1);
        wait_idle();
        cfg_write(CFG_SHIFT, 32'd0);
        send(32'h8000_0000);
        pulse_flush();
        wait_words(base + 2);
        expect_word("sat_max", base + 1, 32'h0000_007F, 3'd1);
        wait_idle();
        cfg_write(CFG_ACT_MIN, 32'h0000_00F6);
        cfg_write(CFG_ACT_MAX, 32'h0000_000A);
        send(32'h8000_0000);
        send(32'h7FFF_FFFF);
        pulse_flush();
        wait_words(base + 3);
        expect_word("act_clamp", base + 2, 32'h0000_F60A, 3'd2);

        // Backpressure: 11 accepts fill output reg, packer and four stages
        do_reset();
        base = got_data.size();
        bus.out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 40; c++) begin
            bus.in_valid = (idx < 12);
            bus.in_acc   = 32'(2 * (idx + 1));
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
        end
        bus.in_valid = 1'b0;
        check("bp_accepted", 32'(idx), 32'd11);
        check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        check("bp_no_words", 32'(got_data.size()), 32'(base));
        bus.out_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 12; c++) begin
            bus.in_valid = 1'b1;
            bus.in_acc   = 32'(2 * (idx + 1));
            @(negedge clk);
            if (bus.in_ready) idx++;
            tick();
        end
        bus.in_valid = 1'b0;
        wait_words(base + 3);
        expect_word("bp_w0", base, 32'h0403_0201, 3'd4);
        expect_word("bp_w1", base + 1, 32'h0807_0605, 3'd4);
        expect_word("bp_w2", base + 2, 32'h0C0B_0A09, 3'd4);
        repeat (10) tick();
        check("bp_word_count", 32'(got_data.size()), 32'(base + 3));

        // Config write while busy is dropped and latches cfg_err
        wait_idle();
        base = got_data.size();
        bus.out_ready = 1'b0;
        send(32'd50);
        cfg_write(CFG_BIAS, 32'd1000);
        @(negedge clk);
        check("cfg_err_set", 32'(bus.cfg_err), 32'd1);
        tick();
        pulse_flush();
        repeat (10) tick();
        bus.out_ready = 1'b1;
        wait_words(base + 1);
        expect_word("cfg_busy_ignored", base, 32'h0000_0019, 3'd1);
        wait_idle();
        check("cfg_err_sticky", 32'(bus.cfg_err), 32'd1);

        // Reset mid-stream discards everything in flight
        base = got_data.size();
        bus.out_ready = 1'b0;
        send(32'd2);
        send(32'd4);
        send(32'd6);
        send(32'd8);
        send(32'd10);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_cfg_err", 32'(bus.cfg_err), 32'd0);
        tick();
        bus.out_ready = 1'b1;
        repeat (20) tick();
        check("midrst_no_stale", 32'(got_data.size()), 32'(base));
        send(32'd2);
        send(32'd4);
        send(32'd6);
        send(32'd8);
        wait_words(base + 1);
        expect_word("post_reset", base, 32'h0403_0201, 3'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv1d_requant_packer.md
Name: conv1d_requant_packer

Overview:
- Downstream stage of the CFU conv1d datapath.
- Consumes signed 32-bit conv1d accumulator results and requantizes each one to int8 using the TFLite int8 scheme: bias, fixed-point multiply, rounding shift, output offset, activation clamp.
- Packs four int8 results per 32-bit word and hands packed words to the CFU response path over a valid/ready handshake.
- Per-layer constants are loaded through a small config write port.

Parameters:
- PIPE_STAGES, 4, arithmetic pipeline depth. Fixed at 4; any other value is illegal.
- MAX_SHIFT, 31, largest legal right-shift amount.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  accumulator valid.
- in_ready  out  1  stage accepts an accumulator this cycle.
- in_acc  in  32  signed accumulator.
- flush  in  1  one-cycle pulse: emit the partial word once the pipeline drains.
- cfg_we  in  1  config write strobe.
- cfg_sel  in  3  register select: 0 bias, 1 mult, 2 shift, 3 out_offset, 4 act_min, 5 act_max.
- cfg_data  in  32  config write data.
- busy  out  1  pipeline or packer holds data.
- cfg_err  out  1  sticky; set when a config write is attempted while busy.
- out_valid  out  1  packed word valid.
- out_ready  in  1  consumer accepts the word.
- out_data  out  32  packed int8 x4; the first result goes in byte 0.
- out_bytes  out  3  number of valid bytes in out_data, 1..4.

Behaviour:
- Reset values:
  - out_valid=0, out_data=0, out_bytes=0, busy=0, cfg_err=0, in_ready=1.
  - All pipeline valid bits and the pack count clear.
  - Config registers: bias=0, mult=0x40000000, shift=0, out_offset=0, act_min=-128, act_max=127.
- Reset mid-operation discards all in-flight data with no output.
- Config:
  - A write with busy=0 updates the selected register on the next edge.
  - A write with busy=1 is ignored and sets cfg_err.
  - shift values above MAX_SHIFT store as MAX_SHIFT.
  - act_min and act_max use cfg_data[7:0], signed.
  - cfg_sel values 6 and 7 are ignored.
- Pipeline (advances only when not stalled):
  - S1: x = in_acc + bias, 32-bit wraparound.
  - S2: p = x * mult as signed 64-bit. Saturation flag sat = (x == mult == INT32_MIN).
  - S3: y = sat ? INT32_MAX : (p + nudge) / 2^31, where nudge = 2^30 if p >= 0, else 1 - 2^30, and the division truncates toward zero.
  - S4: r = (y >>> shift) + (rem > thr), where mask = 2^shift - 1, rem = y & mask, thr = (mask >> 1) + (y < 0).
  - S4 continued: z = r + out_offset, evaluated in 33-bit, then clamped to [act_min, act_max] and truncated to int8.
- Latency: an accumulator accepted at cycle t reaches the packer at edge t+4.
- Packer:
  - Holds up to 3 bytes. The 4th byte completes the word and moves it to the output register with out_bytes=4.
  - The output register holds one word. out_valid stays asserted with out_data stable until out_ready.
  - A word completes in the same cycle the output register drains (out_valid & out_ready): new word loads, out_valid stays 1, no bubble.
- Stall: stall = S4 valid and the packer needs the output register while it is full and not draining. A stall freezes S1..S4 and drops in_ready. in_ready = ~stall.
- Flush:
  - flush is latched.
  - Once S1..S4 are empty and the output register is free, the partial word (1..3 bytes) is emitted. Unused bytes are 0 and out_bytes equals the byte count.
  - Flush with 0 pending bytes emits nothing and clears the latch.
  - Flush asserted together with in_valid: that accumulator is included before the flush takes effect.
- busy = any stage valid | pack count != 0 | out_valid | flush latch.

Decomposition:
- Shared package (conv1d_pkg): cfg_sel encodings, INT32_MIN/INT32_MAX, int8 clamp defaults, reset value of mult.
- One natural sub-module: requant_srdhm, the S2/S3 saturating rounding doubling high-multiply.
- Shift, offset, clamp and packing stay in this module.

Test Plan:
- Default config, inputs 100, 200, -100, 1000, out_ready=1 -> one word 0x7FCE6432, out_bytes=4, first out_valid 4 cycles after the 4th accept.
- mult=0x40000000, shift=1, bias=0, inputs 3, -3, 6, -6 -> intermediate y values 2, -1, 3, -3 -> outputs 1, -1, 2, -2 -> word 0xFE02FF01.
- Saturation: bias=0, mult=0x80000000, input 0x80000000 -> y=INT32_MAX -> clamped byte 0x7F. With act_min=-10, act_max=10 -> 0x0A.
- Backpressure: out_ready=0, stream 12 inputs -> in_ready drops once the pipeline and packer are full; releasing out_ready yields 3 words in order with no loss or duplication.
- Flush after 2 inputs (50, 100 with default config, giving bytes 25 and 50) -> out_data=0x00003219, out_bytes=2. A second flush with nothing pending -> no output.
- Config write while busy -> register unchanged, cfg_err=1 until reset. Reset mid-stream -> out_valid=0 next cycle and no stale words afterwards.
